// File: rtl/exp2_fixed.sv
// Sequential fixed-point antilog y = 2^x. Optional round-half-up on right shifts: define EXP2_ROUND_EN.
// Latency: accept at edge 0, out_valid_o high after edge N+2; one result per N+4 cycles at full rate.
// Backpressure: out_valid_o/y_o/sat_o hold indefinitely until out_ready_i; in_ready_o is low while busy.
module exp2_fixed #(
    parameter int M = 2,
    parameter int N = 5   // legal range 1..16
) (
    input  logic         clk_i,
    input  logic         rstn_i,      // synchronous reset, active-high
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [M+N:0] x_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [M+N:0] y_o,
    output logic         sat_o
);

    localparam int W  = M + N + 1;
    localparam int RW = 22 + W + 1;   // holds acc shifted left below the saturation point, plus rounding carry
    localparam logic [21:0]  ONE  = 22'd1048576;   // 1.0 in Q2.20
    localparam logic [W-1:0] MAXV = '1;

    typedef enum logic [1:0] {IDLE, MUL, SHIFT, DONE} state_t;

    state_t       state, state_nxt;
    logic [M:0]   ip_q, ip_nxt;        // integer part of x (floor), signed
    logic [N-1:0] frac, frac_nxt;      // fraction bits, consumed MSB first
    logic [21:0]  acc, acc_nxt;        // running product, Q2.20, stays in [1,2)
    logic [4:0]   k, k_nxt;
    logic [W-1:0] y_nxt;
    logic         sat_nxt, ov_nxt, ir_nxt;
    logic [43:0]  prod;
    logic signed [31:0] sh;
    logic [31:0]  rs;
    logic [RW-1:0] r;

    // C[k] = 2^(2^-k) in Q2.20, truncated
    function automatic logic [21:0] c_tab(input logic [4:0] idx);
        case (idx)
            5'd1:    c_tab = 22'd1482910;
            5'd2:    c_tab = 22'd1246974;
            5'd3:    c_tab = 22'd1143480;
            5'd4:    c_tab = 22'd1095000;
            5'd5:    c_tab = 22'd1071536;
            5'd6:    c_tab = 22'd1059994;
            5'd7:    c_tab = 22'd1054269;
            5'd8:    c_tab = 22'd1051418;
            5'd9:    c_tab = 22'd1049996;
            5'd10:   c_tab = 22'd1049286;
            5'd11:   c_tab = 22'd1048930;
            5'd12:   c_tab = 22'd1048753;
            5'd13:   c_tab = 22'd1048664;
            5'd14:   c_tab = 22'd1048620;
            5'd15:   c_tab = 22'd1048598;
            5'd16:   c_tab = 22'd1048587;
            default: c_tab = ONE;
        endcase
    endfunction

    assign prod = 44'(acc) * 44'(c_tab(k));

    // State and datapath registers; reset drops any transaction in flight
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            state       <= IDLE;
            ip_q        <= '0;
            frac        <= '0;
            acc         <= '0;
            k           <= '0;
            y_o         <= '0;
            sat_o       <= 1'b0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b0;
        end else begin
            state       <= state_nxt;
            ip_q        <= ip_nxt;
            frac        <= frac_nxt;
            acc         <= acc_nxt;
            k           <= k_nxt;
            y_o         <= y_nxt;
            sat_o       <= sat_nxt;
            out_valid_o <= ov_nxt;
            in_ready_o  <= ir_nxt;
        end
    end

    // Next-state and datapath: one table multiply per fraction bit, then one scaling shift
    always_comb begin
        state_nxt = state;
        ip_nxt    = ip_q;
        frac_nxt  = frac;
        acc_nxt   = acc;
        k_nxt     = k;
        y_nxt     = y_o;
        sat_nxt   = sat_o;
        ov_nxt    = out_valid_o;
        sh        = '0;
        rs        = '0;
        r         = '0;
        case (state)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    ip_nxt    = x_i[W-1:N];
                    frac_nxt  = x_i[N-1:0];
                    acc_nxt   = ONE;
                    k_nxt     = 5'd1;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (frac[N-1]) acc_nxt = 22'(prod >> 20);
                frac_nxt = frac << 1;
                k_nxt    = k + 5'd1;
                if (k == 5'(N)) state_nxt = SHIFT;
            end
            SHIFT: begin
                sh = 32'($signed(ip_q)) + 32'(N) - 32'sd20;
                if (sh >= 0) begin
                    // acc >= 1.0, so any shift reaching bit W overflows regardless of acc
                    if (sh >= 32'(W) - 32'sd20) r = '1;
                    else                        r = RW'(acc) << sh;
                end else begin
                    rs = 32'(-sh);
                    if (rs >= 32'd22) begin
                        r = '0;   // below half an LSB even after rounding
                    end else begin
`ifdef EXP2_ROUND_EN
                        r = (RW'(acc) + (RW'(1) << (rs - 32'd1))) >> rs;
`else
                        r = RW'(acc) >> rs;
`endif
                    end
                end
                sat_nxt   = (r > RW'(MAXV));
                y_nxt     = sat_nxt ? MAXV : r[W-1:0];
                state_nxt = DONE;
            end
            DONE: begin
                if (out_valid_o && out_ready_i) begin
                    ov_nxt    = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    ov_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        ir_nxt = (state_nxt == IDLE);
    end

endmodule

// File: tb/tb_exp2_fixed.sv
// Randomized + directed bench for exp2_fixed (M=2, N=5).
// Driver pushes expected results into a queue; a negedge monitor pops and compares.
// Reference model evaluates 2^x from the integer/fraction decomposition with plain arithmetic.
module tb_exp2_fixed;

    localparam int M = 2;
    localparam int N = 5;
    localparam int W = M + N + 1;

    typedef struct {
        logic [W-1:0] y;
        logic         sat;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] y;
    logic         sat;

    int     compared = 0;
    int     mismatched = 0;
    int     cyc = 0;
    bit     hold = 1'b0;
    bit     rnd_bp = 1'b0;
    bit     seen = 1'b0;
    exp_t   q[$];
    exp_t   mon_e;
    longint ctab [1:16];

    exp2_fixed #(.M(M), .N(N)) dut (
        .clk_i       (clk),
        .rstn_i      (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .x_i         (x),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .y_o         (y),
        .sat_o       (sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // 2^x = 2^floor(x) * 2^frac, fraction built from the truncated Q2.20 constants
    function automatic void model(input logic [W-1:0] xv, output logic [W-1:0] ey, output logic es);
        longint acc, r;
        int xi, ip, fr, sh;
        xi  = int'($signed(xv));
        ip  = xi >>> N;
        fr  = xi & ((1 << N) - 1);
        acc = longint'(1) << 20;
        for (int b = 1; b <= N; b++)
            if (((fr >> (N - b)) & 1) != 0) acc = (acc * ctab[b]) >> 20;
        sh = ip + N - 20;
        if (sh >= 0) begin
            r = acc << sh;
        end else begin
`ifdef EXP2_ROUND_EN
            r = (acc + (longint'(1) << (-sh - 1))) >> (-sh);
`else
            r = acc >> (-sh);
`endif
        end
        if (r > (longint'(1) << W) - 1) begin
            ey = '1;
            es = 1'b1;
        end else begin
            ey = r[W-1:0];
            es = 1'b0;
        end
    endfunction

    // Called just after a negedge; returns just after the negedge following acceptance
    task automatic send(input logic [W-1:0] xv, input logic [W-1:0] ey, input logic es);
        int   t = 0;
        exp_t e;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            bound_fail("accept_wait");
            return;
        end
        in_valid = 1'b1;
        x        = xv;
        @(negedge clk);
        in_valid  = 1'b0;
        e.y       = ey;
        e.sat     = es;
        e.acc_cyc = cyc;
        q.push_back(e);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) bound_fail("drain_wait");
        repeat (3) @(negedge clk);
    endtask

    // Consumer readiness changes just after the active edge
    always begin
        @(posedge clk);
        #2;
        if (!hold) out_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Monitor: latency on first sight of each result, value check at handshake
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (q.size() == 0) bound_fail("unexpected_output");
                else chk("latency", cyc - q[0].acc_cyc, N + 2);
            end
            if (out_ready) begin
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    chk("y", y, mon_e.y);
                    chk("sat", sat, mon_e.sat);
                end
                seen = 1'b0;
            end
        end
    end

    initial begin
        logic [W-1:0] dx [7];
        logic [W-1:0] dy [7];
        logic         ds [7];
        logic [W-1:0] xv, ey;
        logic         es;
        int           t;

        for (int k = 1; k <= 16; k++)
            ctab[k] = longint'($floor((2.0 ** (1.0 / (2.0 ** k))) * 1048576.0));

        dx = '{8'h00, 8'h20, 8'hE0, 8'h80, 8'h10, 8'h30, 8'h60};
`ifdef EXP2_ROUND_EN
        dy = '{8'h20, 8'h40, 8'h10, 8'h02, 8'h2D, 8'h5B, 8'hFF};
`else
        dy = '{8'h20, 8'h40, 8'h10, 8'h02, 8'h2D, 8'h5A, 8'hFF};
`endif
        ds = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_sat", sat, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        // Directed vectors with known results
        for (int i = 0; i < 7; i++) send(dx[i], dy[i], ds[i]);
        // Edge values through the model: top of range, just below overflow, most negative fractions
        foreach (dx[i]) begin end
        xv = 8'h5F; model(xv, ey, es); send(xv, ey, es);
        xv = 8'h7F; model(xv, ey, es); send(xv, ey, es);
        xv = 8'h81; model(xv, ey, es); send(xv, ey, es);
        xv = 8'h9F; model(xv, ey, es); send(xv, ey, es);
        wait_drain();

        // Long backpressure: output frozen, new input ignored
        hold      = 1'b1;
        out_ready = 1'b0;
        send(8'h20, 8'h40, 1'b0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) bound_fail("stall_valid_wait");
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                in_valid = 1'b1;
                x        = 8'h00;
            end
            if (i == 6) in_valid = 1'b0;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_y", y, 8'h40);
            chk("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        hold = 1'b0;
        wait_drain();

        // Reset while multiplying: transaction dropped, no stale data afterwards
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1'b1;
        x        = 8'h60;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_y", y, 0);
        chk("midrst_sat", sat, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready_rise", in_ready, 1);
        send(8'h20, 8'h40, 1'b0);
        wait_drain();

        // Random inputs with random consumer backpressure
        rnd_bp = 1'b1;
        repeat (80) begin
            xv = W'($urandom_range(0, (1 << W) - 1));
            model(xv, ey, es);
            send(xv, ey, es);
        end
        wait_drain();
        rnd_bp = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
